// File: rtl/icache_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory command/response port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface icache_mem_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              i_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_last;

  logic              d_valid;
  logic              d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [31:0]       d_wdata;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_we, d_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output i_ready, i_rvalid, i_rdata, i_last, d_ready, d_rvalid, d_rdata,
           mem_valid, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_we, d_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  i_ready, i_rvalid, i_rdata, i_last, d_ready, d_rvalid, d_rdata,
           mem_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an I-cache line refill
// requester (port 0, bursts) and a data requester (port 1, single words).
module icache_mem_arbiter #(
  parameter int BURST_LOG = 2,
  parameter int ADDR_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_mem_arbiter_if.slave  bus,
  output logic                 proto_error
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = BURST_LOG + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << BURST_LOG) - 1);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   resp_cnt;
  logic               prio0;
  logic               grant0;
  logic               grant1;
  logic               port0_busy;
  logic               rsp_ok;
  logic               rsp_unexp;
  logic [ADDR_W-1:0]  line_base;
  logic               unused_addr_bits;

  assign grant0 = (state == IDLE) && bus.i_valid && (!bus.d_valid || prio0);
  assign grant1 = (state == IDLE) && bus.d_valid && (!bus.i_valid || !prio0);

  // Ready is a same-cycle handshake; gating with rst keeps it low while held in reset.
  assign bus.i_ready = rst & grant0;
  assign bus.d_ready = rst & grant1;

  assign port0_busy = (state == ISSUE0) || (state == WAIT0);
  assign rsp_ok     = bus.mem_rvalid && (state != IDLE) && (resp_cnt != issue_cnt);
  assign rsp_unexp  = bus.mem_rvalid && !rsp_ok;
  assign line_base  = {bus.i_addr[ADDR_W-1:BURST_LOG+2], {(BURST_LOG+2){1'b0}}};
  assign unused_addr_bits = ^{bus.i_addr[BURST_LOG+1:0], bus.d_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      issue_cnt     <= '0;
      resp_cnt      <= '0;
      prio0         <= 1'b1;
      proto_error   <= 1'b0;
      bus.i_rvalid  <= 1'b0;
      bus.i_last    <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.i_rvalid <= 1'b0;
      bus.i_last   <= 1'b0;
      bus.d_rvalid <= 1'b0;
      if (rsp_unexp) proto_error <= 1'b1;

      case (state)
        IDLE: begin
          if (grant0) begin
            prio0         <= 1'b0;
            issue_cnt     <= '0;
            resp_cnt      <= '0;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= line_base;
            state         <= ISSUE0;
          end else if (grant1) begin
            prio0         <= 1'b1;
            issue_cnt     <= '0;
            resp_cnt      <= '0;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
            bus.mem_wdata <= bus.d_wdata;
            state         <= ISSUE1;
          end
        end
        ISSUE0: begin
          if (bus.mem_ready) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_IDX) begin
              bus.mem_valid <= 1'b0;
              state         <= WAIT0;
            end else begin
              bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
            end
          end
        end
        ISSUE1: begin
          if (bus.mem_ready) begin
            issue_cnt     <= CNT_W'(1);
            bus.mem_valid <= 1'b0;
            state         <= WAIT1;
          end
        end
        default: ;
      endcase

      // Response routing; the final response of a transaction returns us to IDLE.
      if (rsp_ok) begin
        if (port0_busy) begin
          resp_cnt     <= resp_cnt + 1'b1;
          bus.i_rvalid <= 1'b1;
          bus.i_last   <= (resp_cnt == LAST_IDX);
          if (resp_cnt == LAST_IDX) state <= IDLE;
        end else begin
          resp_cnt     <= resp_cnt + 1'b1;
          bus.d_rvalid <= 1'b1;
          state        <= IDLE;
        end
      end
    end
  end

  // Response data path: registered alongside the rvalid flags, no reset needed.
  always_ff @(posedge clk) begin
    if (rsp_ok && port0_busy)  bus.i_rdata <= bus.mem_rdata[DATA_W-1:0];
    if (rsp_ok && !port0_busy) bus.d_rdata <= bus.mem_rdata[DATA_W-1:0];
  end

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed bench for icache_mem_arbiter: a transaction-level scoreboard with a
// memory model, checked every cycle, plus literal expectations per scenario.
module tb_icache_mem_arbiter;
  localparam int ADDR_W    = 24;
  localparam int BURST_LOG = 2;
  localparam int BEATS     = 1 << BURST_LOG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_error;

  icache_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  icache_mem_arbiter #(.BURST_LOG(BURST_LOG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [23:0] addr; logic we; logic [31:0] wdata;} cmd_t;
  typedef struct packed {logic [31:0] due; logic [31:0] data;} rsp_t;

  cmd_t exp_cmd[$];
  rsp_t mem_q[$];
  logic [31:0] mem [logic [23:0]];

  bit busy, owner_d, prio0 = 1'b1;
  int outstanding, rsp_seen;
  bit exp_irv, exp_ilast, exp_drv, exp_proto;
  logic [31:0] exp_rdata;
  int unsigned cyc = 0;

  bit spur = 1'b0;
  int stall_at = -1, stall_left = 0;

  int n_acc, n_irv, n_ilast, n_drv, n_iready_cyc, n_dready_cyc, stall_seen, hold_good;
  int grant_log[$];
  logic [23:0] addr_log[$];
  logic        we_log[$];
  logic [31:0] irdata_log[$], drdata_log[$];

  function automatic logic [31:0] mem_read(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 | {8'h00, a};
  endfunction

  task automatic clear_stats();
    n_acc = 0; n_irv = 0; n_ilast = 0; n_drv = 0;
    n_iready_cyc = 0; n_dready_cyc = 0; stall_seen = 0; hold_good = 0;
    grant_log.delete(); addr_log.delete(); we_log.delete();
    irdata_log.delete(); drdata_log.delete();
  endtask

  // Memory model + scoreboard: compare this cycle, then advance the model.
  always @(negedge clk) begin
    bit rv, stalled, gi, gd;
    logic [31:0] d;
    cyc++;
    if (!rst) begin
      chk("rst_outputs",
          {bus.i_ready, bus.d_ready, bus.i_rvalid, bus.i_last, bus.d_rvalid,
           bus.mem_valid, bus.mem_we, proto_error, bus.mem_addr, bus.mem_wdata}, 64'h0);
      bus.mem_rvalid = 1'b0;
      bus.mem_ready  = 1'b1;
      mem_q.delete(); exp_cmd.delete();
      busy = 0; prio0 = 1; outstanding = 0; rsp_seen = 0;
      exp_irv = 0; exp_ilast = 0; exp_drv = 0; exp_proto = 0;
      spur = 0;
    end else begin
      gi = !busy && bus.i_valid && (!bus.d_valid || prio0);
      gd = !busy && bus.d_valid && (!bus.i_valid || !prio0);
      chk("i_ready", 64'(bus.i_ready), 64'(gi));
      chk("d_ready", 64'(bus.d_ready), 64'(gd));
      chk("i_rvalid", 64'(bus.i_rvalid), 64'(exp_irv));
      chk("i_last", 64'(bus.i_last), 64'(exp_ilast));
      if (exp_irv) chk("i_rdata", 64'(bus.i_rdata), 64'(exp_rdata));
      chk("d_rvalid", 64'(bus.d_rvalid), 64'(exp_drv));
      if (exp_drv) chk("d_rdata", 64'(bus.d_rdata), 64'(exp_rdata));
      chk("proto_error", 64'(proto_error), 64'(exp_proto));
      chk("mem_valid", 64'(bus.mem_valid), 64'(exp_cmd.size() != 0));
      if (exp_cmd.size() != 0)
        chk("mem_cmd", 64'({bus.mem_addr, bus.mem_we, bus.mem_wdata}), 64'(exp_cmd[0]));

      if (bus.i_ready)  n_iready_cyc++;
      if (bus.d_ready)  n_dready_cyc++;
      if (bus.i_rvalid) begin n_irv++; irdata_log.push_back(bus.i_rdata); end
      if (bus.i_last)   n_ilast++;
      if (bus.d_rvalid) begin n_drv++; drdata_log.push_back(bus.d_rdata); end

      stalled = bus.mem_valid && (n_acc == stall_at) && (stall_left > 0);
      bus.mem_ready = !stalled;
      if (stalled) begin
        stall_left--; stall_seen++;
        if (bus.mem_addr == 24'h000014) hold_good++;
      end
      rv = spur || (mem_q.size() > 0 && mem_q[0].due == cyc);
      bus.mem_rvalid = rv;
      if (spur) bus.mem_rdata = 32'h5A5A_5A5A;
      else if (rv) bus.mem_rdata = mem_q.pop_front().data;
      else bus.mem_rdata = 32'h0;
      spur = 0;

      exp_irv = 0; exp_ilast = 0; exp_drv = 0;
      if (rv) begin
        if (!busy || outstanding == 0) exp_proto = 1;
        else begin
          outstanding--; rsp_seen++;
          exp_rdata = bus.mem_rdata;
          if (owner_d) begin exp_drv = 1; busy = 0; end
          else begin
            exp_irv = 1;
            exp_ilast = (rsp_seen == BEATS);
            if (rsp_seen == BEATS) busy = 0;
          end
        end
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (exp_cmd.size() > 0) void'(exp_cmd.pop_front());
        n_acc++;
        addr_log.push_back(bus.mem_addr);
        we_log.push_back(bus.mem_we);
        if (bus.mem_we) begin mem[bus.mem_addr] = bus.mem_wdata; d = 32'h0; end
        else d = mem_read(bus.mem_addr);
        mem_q.push_back('{due: cyc + 2, data: d});
        outstanding++;
      end
      if (bus.i_valid && bus.i_ready) begin
        busy = 1; owner_d = 0; prio0 = 0; outstanding = 0; rsp_seen = 0;
        grant_log.push_back(0);
        for (int k = 0; k < BEATS; k++)
          exp_cmd.push_back('{addr: (bus.i_addr & ~24'(4*BEATS-1)) + 24'(4*k), we: 1'b0, wdata: 32'h0});
      end
      if (bus.d_valid && bus.d_ready) begin
        busy = 1; owner_d = 1; prio0 = 1; outstanding = 0; rsp_seen = 0;
        grant_log.push_back(1);
        exp_cmd.push_back('{addr: bus.d_addr & ~24'h3, we: bus.d_we, wdata: bus.d_wdata});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1); rst = 1'b0;
    tick(2); rst = 1'b1;
  endtask

  task automatic req_i(input logic [23:0] a);
    tick(1);
    bus.i_valid = 1'b1; bus.i_addr = a;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.i_ready) begin tick(1); bus.i_valid = 1'b0; return; end
    end
    chk("i_handshake_timeout", 64'd1, 64'd0);
    bus.i_valid = 1'b0;
  endtask

  task automatic req_d(input logic [23:0] a, input logic we, input logic [31:0] wd);
    tick(1);
    bus.d_valid = 1'b1; bus.d_addr = a; bus.d_we = we; bus.d_wdata = wd;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.d_ready) begin tick(1); bus.d_valid = 1'b0; return; end
    end
    chk("d_handshake_timeout", 64'd1, 64'd0);
    bus.d_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (!busy && exp_cmd.size() == 0 && mem_q.size() == 0 && !exp_irv && !exp_drv) begin
        tick(1);
        return;
      end
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [23:0] ea [4];
    bool_guard: begin end
    ea = '{24'h000010, 24'h000014, 24'h000018, 24'h00001C};
    bus.i_valid = 0; bus.i_addr = '0; bus.d_valid = 0; bus.d_addr = '0;
    bus.d_we = 0; bus.d_wdata = '0; bus.mem_ready = 1; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    #1 rst = 1'b0;
    tick(3); rst = 1'b1;

    // Single refill
    clear_stats();
    req_i(24'h000013);
    wait_done();
    chk("refill_grants", 64'(grant_log.size()), 64'd1);
    chk("refill_iready_cycles", 64'(n_iready_cyc), 64'd1);
    chk("refill_cmds", 64'(addr_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("refill_addr", 64'(addr_log[k]), 64'(ea[k]));
    chk("refill_irvalid", 64'(n_irv), 64'd4);
    chk("refill_ilast", 64'(n_ilast), 64'd1);
    chk("refill_word0", 64'(irdata_log[0]), 64'h0000_0000_A000_0010);
    chk("refill_word3", 64'(irdata_log[3]), 64'h0000_0000_A000_001C);

    // Data write then read
    clear_stats();
    req_d(24'h800004, 1'b1, 32'hDEAD_BEEF);
    wait_done();
    req_d(24'h800004, 1'b0, 32'h0);
    wait_done();
    chk("wr_rd_we0", 64'(we_log[0]), 64'd1);
    chk("wr_rd_we1", 64'(we_log[1]), 64'd0);
    chk("wr_rd_addr0", 64'(addr_log[0]), 64'h800004);
    chk("wr_rd_addr1", 64'(addr_log[1]), 64'h800004);
    chk("wr_rd_drvalid", 64'(n_drv), 64'd2);
    chk("wr_rd_rdata", 64'(drdata_log[1]), 64'h0000_0000_DEAD_BEEF);

    // Round-robin conflict from reset
    do_reset();
    clear_stats();
    bus.i_valid = 1; bus.i_addr = 24'h000100;
    bus.d_valid = 1; bus.d_addr = 24'h000200; bus.d_we = 0; bus.d_wdata = '0;
    for (int k = 0; k < 300 && grant_log.size() < 3; k++) tick(1);
    bus.i_valid = 0; bus.d_valid = 0;
    wait_done();
    chk("rr_grants", 64'(grant_log.size()), 64'd3);
    chk("rr_first", 64'(grant_log[0]), 64'd0);
    chk("rr_second", 64'(grant_log[1]), 64'd1);
    chk("rr_third", 64'(grant_log[2]), 64'd0);
    chk("rr_iready_cycles", 64'(n_iready_cyc), 64'd2);
    chk("rr_dready_cycles", 64'(n_dready_cyc), 64'd1);

    // Backpressure on the second refill command
    clear_stats();
    stall_at = 1; stall_left = 5;
    req_i(24'h000010);
    wait_done();
    stall_at = -1;
    chk("bp_stall_cycles", 64'(stall_seen), 64'd5);
    chk("bp_addr_held", 64'(hold_good), 64'd5);
    chk("bp_cmds", 64'(n_acc), 64'd4);
    chk("bp_resps", 64'(n_irv), 64'd4);

    // Reset in the middle of a burst
    clear_stats();
    req_i(24'h000040);
    for (int k = 0; k < 100 && n_irv < 2; k++) tick(1);
    chk("mid_two_resps", 64'(n_irv), 64'd2);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(6);
    chk("mid_no_irv_after", 64'(n_irv), 64'd2);
    req_d(24'h000300, 1'b0, 32'h0);
    wait_done();
    chk("mid_d_done", 64'(n_drv), 64'd1);
    chk("mid_d_data", 64'(drdata_log[0]), 64'h0000_0000_A000_0300);
    chk("mid_proto", 64'(proto_error), 64'd0);

    // Spurious response while idle
    clear_stats();
    spur = 1'b1;
    tick(5);
    chk("spur_proto", 64'(proto_error), 64'd1);
    chk("spur_no_irv", 64'(n_irv), 64'd0);
    chk("spur_no_drv", 64'(n_drv), 64'd0);
    req_d(24'h000304, 1'b0, 32'h0);
    wait_done();
    chk("spur_d_done", 64'(n_drv), 64'd1);
    chk("spur_sticky", 64'(proto_error), 64'd1);
    do_reset();
    tick(1);
    chk("spur_cleared", 64'(proto_error), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
